// File: rtl/if_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the
// decode-side valid/ready channel. master = prefetch unit, slave = memory/decode.
interface if_prefetch_unit_if #(
    parameter int IW = 19,
    parameter int AW = 10
);
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_npc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_valid, out_instr, out_pc, out_npc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_valid, out_instr, out_pc, out_npc,
        output out_ready
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front end: sequential fetch, in-order queue, redirect flush.
// Optional macro PREDECODE_HALT_EN: a kept HLT word (opcode 4'b0100) parks fetch until redirect.
module if_prefetch_unit #(
    parameter int IW    = 19,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [AW-1:0]            redirect_pc,
    input  logic                     halt,
    if_prefetch_unit_if.master       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_FETCH  = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        q_mem [DEPTH];

    logic [CW:0]   inflight;
    logic          req_valid, acc, rsp_keep, rsp_drop, push, pop, out_valid;
    logic          hlt_hit, hlt_lock;

    assign inflight = {1'b0, count_q} + {1'b0, outstanding_q};
    // A response arriving in the redirect cycle belongs to the old stream.
    assign rsp_keep = bus.imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != '0) && !redirect_valid;
    assign push     = rsp_keep;

`ifdef PREDECODE_HALT_EN
    logic hlt_lock_q;
    assign hlt_hit  = rsp_keep && (bus.imem_rsp_data[IW-1 -: 4] == 4'b0100);
    assign hlt_lock = hlt_lock_q;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)               hlt_lock_q <= 1'b0;
        else if (redirect_valid) hlt_lock_q <= 1'b0;
        else if (hlt_hit)        hlt_lock_q <= 1'b1;
    end
`else
    assign hlt_hit  = 1'b0;
    assign hlt_lock = 1'b0;
`endif

    // Credit rule: queued + in-flight never exceeds DEPTH, so pushes always fit.
    assign req_valid = !reset && (state_q == S_FETCH) && !halt && !redirect_valid &&
                       !hlt_hit && (inflight < (CW+1)'(DEPTH));
    assign acc       = req_valid && bus.imem_req_ready;
    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(acc) - CW'(bus.imem_rsp_valid);
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - CW'(bus.imem_rsp_valid);
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (acc)      fetch_pc_d = fetch_pc_q + AW'(1);
            if (push)     rsp_pc_d   = rsp_pc_q + AW'(1);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = halt ? S_HALTED : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (halt || hlt_hit)   state_d = S_HALTED;
                S_HALTED: if (!halt && !hlt_lock) state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= '0;
            rsp_pc_q      <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (push) q_mem[wr_ptr_q] <= '{instr: bus.imem_rsp_data, pc: rsp_pc_q};
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_instr      = q_mem[rd_ptr_q].instr;
    assign bus.out_pc         = q_mem[rd_ptr_q].pc;
    assign bus.out_npc        = q_mem[rd_ptr_q].pc + AW'(1);
    assign count              = count_q;
    assign halted             = (state_q == S_HALTED);

    a_no_overflow: assert property (@(posedge clk1) disable iff (reset)
        !(push && (count_q == CW'(DEPTH))));
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a variable-latency in-order memory model.
module tb_if_prefetch_unit;
    logic       clk1 = 1'b0;
    logic       reset = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [9:0] redirect_pc = '0;
    logic       halt = 1'b0;
    logic [2:0] count;
    logic       halted;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int acc_cnt;
    bit hlt_en = 1'b0;

    logic [2:0] v_q;
    logic [9:0] a_q [3];
    logic [9:0]  obs_pc [$];
    logic [18:0] obs_in [$];
    logic [9:0]  obs_np [$];

    if_prefetch_unit_if #(.IW(19), .AW(10)) bus ();

    if_prefetch_unit #(.IW(19), .AW(10), .DEPTH(4)) dut (
        .clk1(clk1), .reset(reset), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .bus(bus),
        .count(count), .halted(halted)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [18:0] memw(input logic [9:0] a);
        if (hlt_en && a == 10'd5) return {4'b0100, 5'd0, a};
        return {4'hA, a[4:0], a};
    endfunction

    // Memory: fixed latency 'lat' (1..3), always ready, reset together with the DUT.
    always @(posedge clk1 or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            acc_cnt <= 0;
        end else begin
            v_q    <= {v_q[1:0], bus.imem_req_valid && bus.imem_req_ready};
            a_q[2] <= a_q[1];
            a_q[1] <= a_q[0];
            a_q[0] <= bus.imem_req_addr;
            if (bus.imem_req_valid && bus.imem_req_ready) acc_cnt <= acc_cnt + 1;
        end
    end
    assign bus.imem_rsp_valid = v_q[lat-1];
    assign bus.imem_rsp_data  = memw(a_q[lat-1]);

    always @(negedge clk1) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            obs_pc.push_back(bus.out_pc);
            obs_in.push_back(bus.out_instr);
            obs_np.push_back(bus.out_npc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk1);
        reset = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        reset = 1'b0;
        obs_pc.delete();
        obs_in.delete();
        obs_np.delete();
    endtask

    task automatic take_out(input string tag, input logic [9:0] pc);
        int n = 0;
        logic [9:0] np;
        while (obs_pc.size() == 0 && n < 40) begin
            @(negedge clk1);
            n++;
        end
        if (obs_pc.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        np = pc + 10'd1;
        chk({tag, "_pc"},    obs_pc.pop_front(), pc);
        chk({tag, "_instr"}, obs_in.pop_front(), memw(pc));
        chk({tag, "_npc"},   obs_np.pop_front(), np);
    endtask

    initial begin
        int bad;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk1);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_req_addr", bus.imem_req_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_halted", halted, 0);

        // 1: latency 1 streaming, first word two cycles after first accept
        lat = 1;
        do_reset();
        @(posedge clk1);
        @(negedge clk1);
        chk("t1_lat_c1", bus.out_valid, 0);
        @(negedge clk1);
        chk("t1_lat_c2", bus.out_valid, 1);
        for (int i = 0; i < 4; i++) take_out("t1", 10'(i));

        // 2: backpressure fills exactly DEPTH, then drains in order
        bus.out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk1);
        chk("t2_accepts", acc_cnt, 4);
        chk("t2_count", count, 4);
        chk("t2_req_off", bus.imem_req_valid, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) take_out("t2", 10'(i));

        // 3: latency 3, redirect with two in flight drops both stale words
        lat = 3;
        do_reset();
        @(negedge clk1);
        @(negedge clk1);
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        @(negedge clk1);
        redirect_valid = 1'b0;
        chk("t3_drop2", dut.drop_cnt_q, 2);
        take_out("t3", 10'h200);
        chk("t3_drop0", dut.drop_cnt_q, 0);
        take_out("t3b", 10'h201);

        // 4: PC wrap at the top of the address space
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FE;
        @(negedge clk1);
        redirect_valid = 1'b0;
        take_out("t4a", 10'h3FE);
        take_out("t4b", 10'h3FF);
        take_out("t4c", 10'h000);

        // 5: halt mid-stream, queued words still drain, resume sequentially
        bus.out_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge clk1);
        chk("t5_full", count, 4);
        halt = 1'b1;
        bus.out_ready = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clk1);
            #1;
            if (bus.imem_req_valid) bad++;
            if (!halted) bad++;
        end
        chk("t5_halt_quiet", bad, 0);
        @(negedge clk1);
        halt = 1'b0;
        for (int i = 0; i < 6; i++) take_out("t5", 10'(i));
        chk("t5_running", halted, 0);

`ifdef PREDECODE_HALT_EN
        // 6: predecoded HLT at address 5 parks fetch until redirect
        hlt_en = 1'b1;
        bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) take_out("t6", 10'(i));
        repeat (10) @(negedge clk1);
        chk("t6_halted", halted, 1);
        chk("t6_accepts", acc_cnt, 6);
        chk("t6_no_extra", obs_pc.size(), 0);
        redirect_valid = 1'b1;
        redirect_pc = 10'h010;
        @(negedge clk1);
        redirect_valid = 1'b0;
        take_out("t6r", 10'h010);
        chk("t6_resumed", halted, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
